// File: rtl/pixel_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_write_queue
//  Description : Pixel sink between the drawing FSMs and the framebuffer RAM
//                write port. Range-checks each plotted pixel, linearises it to
//                a framebuffer address, buffers it in a small FIFO and drains
//                the FIFO whenever the scan arbiter grants a write slot. Also
//                provides a flush handshake and saturating drop counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_write_queue #(
    parameter int DEPTH = 4,
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  color,
    output logic        busy,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    input  logic        flush_req,
    output logic        flush_done,
    output logic [7:0]  oob_count,
    output logic [7:0]  ovf_count
);

    // Pointer, occupancy and level widths. Occupancy must represent DEPTH,
    // and the busy level (occupancy + stage-1 pixel) one more bit again.
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_AW + 1;
    localparam int c_SW = c_CW + 1;
    // FIFO entry is {addr[14:0], color[2:0]}
    localparam int c_EW = 18;

    localparam logic [8:0]      c_X_LIM    = 9'(H_RES);
    localparam logic [7:0]      c_Y_LIM    = 8'(V_RES);
    localparam logic [14:0]     c_H_RES    = 15'(H_RES);
    localparam logic [c_SW-1:0] c_BUSY_LVL = c_SW'(DEPTH - 1);
    localparam logic [7:0]      c_SAT      = 8'hFF;

    // Flush state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Stage-1 capture registers
    logic            r_s1_valid;
    logic [7:0]      r_s1_x;
    logic [6:0]      r_s1_y;
    logic [2:0]      r_s1_color;

    // FIFO state
    logic [c_EW-1:0] r_fifo [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    // Registered outputs
    logic            r_mem_we;
    logic [14:0]     r_mem_addr;
    logic [2:0]      r_mem_data;
    logic            r_flush_done;
    logic [7:0]      r_oob_count;
    logic [7:0]      r_ovf_count;

    // Flush FSM
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;

    // Combinational helpers
    logic            w_busy;
    logic            w_accept;
    logic            w_in_range;
    logic            w_push;
    logic            w_pop;
    logic            w_drained;
    logic [14:0]     w_s1_addr;
    logic [c_EW-1:0] w_head;
    logic [c_SW-1:0] w_level;

    // Room is reserved for the pixel already in stage 1 plus the one that
    // would be captured this edge, so a full FIFO is never pushed.
    assign w_level    = {1'b0, r_count} + {{c_CW{1'b0}}, r_s1_valid};
    assign w_busy     = (w_level >= c_BUSY_LVL);
    assign w_accept   = plot & ~w_busy;
    assign w_in_range = ({1'b0, x} < c_X_LIM) && ({1'b0, y} < c_Y_LIM);

    // Linear address y*H_RES + x; the constant multiply reduces to shift-add.
    assign w_s1_addr  = ({8'd0, r_s1_y} * c_H_RES) + {7'd0, r_s1_x};

    assign w_push     = r_s1_valid;
    assign w_pop      = (r_count != '0) && mem_ready;
    assign w_head     = r_fifo[r_rd_ptr];

    // A flush is complete only once nothing is in flight anywhere upstream
    assign w_drained  = !r_s1_valid && (r_count == '0) && !w_accept;

    // Stage 1: capture accepted pixels; only in-range pixels become valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_color <= '0;
        end else begin
            r_s1_valid <= w_accept && w_in_range;
            if (w_accept) begin
                r_s1_x     <= x;
                r_s1_y     <= y;
                r_s1_color <= color;
            end
        end
    end

    // FIFO storage: contents need no reset, emptiness lives in the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {w_s1_addr, r_s1_color};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write port: one registered write per granted slot, address/data hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else if (w_pop) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= w_head[c_EW-1:3];
            r_mem_data <= w_head[2:0];
        end else begin
            r_mem_we   <= 1'b0;
        end
    end

    // Saturating drop counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_oob_count <= '0;
            r_ovf_count <= '0;
        end else begin
            if (w_accept && !w_in_range && (r_oob_count != c_SAT)) begin
                r_oob_count <= r_oob_count + 8'd1;
            end
            if (plot && w_busy && (r_ovf_count != c_SAT)) begin
                r_ovf_count <= r_ovf_count + 8'd1;
            end
        end
    end

    // Flush FSM state register; flush_done is registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_flush_done <= (w_state_next == c_ST_DONE);
        end
    end

    // Flush FSM next-state: dropping the request always returns to idle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (flush_req) begin
                    w_state_next = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (!flush_req) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_drained) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (!flush_req) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    assign busy       = w_busy;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign flush_done = r_flush_done;
    assign oob_count  = r_oob_count;
    assign ovf_count  = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pixel_write_queue
//  Description : Self-checking bench for pixel_write_queue. A queue-based
//                pixel-flow model predicts writes, backpressure, flush
//                acknowledge and drop counters; scenario tasks add directed
//                expectations on top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_write_queue;

    localparam int DEPTH = 4;
    localparam int H_RES = 160;
    localparam int V_RES = 120;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        plot      = 1'b0;
    logic [7:0]  x         = '0;
    logic [6:0]  y         = '0;
    logic [2:0]  color     = '0;
    logic        mem_ready = 1'b0;
    logic        flush_req = 1'b0;
    logic        busy;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        flush_done;
    logic [7:0]  oob_count;
    logic [7:0]  ovf_count;

    int n_vec = 0;
    int n_err = 0;

    pixel_write_queue #(
        .DEPTH (DEPTH),
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .color      (color),
        .busy       (busy),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .oob_count  (oob_count),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    // Reference model: a pixel waiting to be linearised, a queue of pending
    // {addr,color} writes, and the externally visible results.
    bit          m_s1v;
    logic [17:0] m_s1_ent;
    logic [17:0] m_q[$];
    bit          m_we;
    logic [14:0] m_addr;
    logic [2:0]  m_data;
    bit          m_flushing;
    bit          m_fd;
    int          m_oob;
    int          m_ovf;

    function automatic bit m_busy();
        return (int'(m_q.size()) + (m_s1v ? 1 : 0)) >= (DEPTH - 1);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    function automatic void model_step();
        bit b;
        bit acc;
        bit inr;
        bit drained;
        b = m_busy();
        if (reset) begin
            m_s1v = 0; m_q.delete(); m_we = 0; m_addr = '0; m_data = '0;
            m_flushing = 0; m_fd = 0; m_oob = 0; m_ovf = 0;
            return;
        end
        acc     = plot && !b;
        inr     = (int'(x) < H_RES) && (int'(y) < V_RES);
        drained = !m_s1v && (m_q.size() == 0) && !acc;
        if (m_fd) begin
            m_fd = flush_req;
        end else if (m_flushing) begin
            if (!flush_req) m_flushing = 0;
            else if (drained) begin m_flushing = 0; m_fd = 1; end
        end else if (flush_req) begin
            m_flushing = 1;
        end
        if ((m_q.size() > 0) && mem_ready) begin
            m_we = 1;
            {m_addr, m_data} = m_q.pop_front();
        end else begin
            m_we = 0;
        end
        if (m_s1v) m_q.push_back(m_s1_ent);
        m_s1v = acc && inr;
        if (m_s1v) m_s1_ent = {15'(int'(y) * H_RES + int'(x)), color};
        if (acc && !inr && m_oob < 255) m_oob++;
        if (plot && b && m_ovf < 255) m_ovf++;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; plot = 0; flush_req = 0; mem_ready = 0;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; plot = 0; flush_req = 0; mem_ready = 0;
        tick();
        tick();
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_vec++; if ({mem_addr, mem_data} !== 18'd0) begin n_err++; $display("FAIL reset_addr_data: got %0h/%0h want 0/0", mem_addr, mem_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
        n_vec++; if ({oob_count, ovf_count} !== 16'd0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", oob_count, ovf_count); end
        reset = 0;
    endtask

    task automatic test_single_pixel();
        do_reset();
        mem_ready = 1;
        plot = 1; x = 8'd5; y = 7'd2; color = 3'b101;
        tick();
        plot = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_vec++;
            if (k == 2) begin
                if (mem_we !== 1'b1 || mem_addr !== 15'd325 || mem_data !== 3'd5) begin
                    n_err++; $display("FAIL single_write: got we=%b addr=%0d data=%0d want 1/325/5", mem_we, mem_addr, mem_data);
                end
            end else if (mem_we !== 1'b0) begin
                n_err++; $display("FAIL single_quiet(k=%0d): got we=%b want 0", k, mem_we);
            end
        end
    endtask

    task automatic test_corners();
        logic [7:0]  cx[4];
        logic [6:0]  cy[4];
        logic [2:0]  cc[4];
        logic [17:0] got[$];
        cx = '{8'd0, 8'd159, 8'd160, 8'd0};
        cy = '{7'd0, 7'd119, 7'd0, 7'd120};
        cc = '{3'd3, 3'd6, 3'd7, 3'd1};
        do_reset();
        mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            plot = 1; x = cx[i]; y = cy[i]; color = cc[i];
            tick();
            if (mem_we) got.push_back({mem_addr, mem_data});
        end
        plot = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_we) got.push_back({mem_addr, mem_data});
        end
        n_vec++; if (got.size() != 2) begin n_err++; $display("FAIL corners_count: got %0d writes want 2", got.size()); end
        while (got.size() < 2) got.push_back('x);
        n_vec++; if (got[0] !== {15'd0, 3'd3}) begin n_err++; $display("FAIL corners_first: got %0h want %0h", got[0], {15'd0, 3'd3}); end
        n_vec++; if (got[1] !== {15'd19199, 3'd6}) begin n_err++; $display("FAIL corners_last: got %0h want %0h", got[1], {15'd19199, 3'd6}); end
        n_vec++; if (oob_count !== 8'd2) begin n_err++; $display("FAIL corners_oob: got %0d want 2", oob_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0]  px[6];
        logic [6:0]  py[6];
        logic [2:0]  pc[6];
        logic [17:0] got[6];
        int          wr_cyc[6];
        int          idx = 0;
        int          we_seen = 0;
        int          nwr = 0;
        bit          saw_busy = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            px[i] = 8'($urandom_range(0, H_RES - 1));
            py[i] = 7'($urandom_range(0, V_RES - 1));
            pc[i] = 3'($urandom);
        end
        mem_ready = 0;
        for (int c = 0; c < 12; c++) begin
            plot = (idx < 6) && !busy;
            if (plot) begin x = px[idx]; y = py[idx]; color = pc[idx]; idx++; end
            tick();
            if (mem_we) we_seen++;
            if (busy) saw_busy = 1;
            n_vec++; if (busy !== m_busy()) begin n_err++; $display("FAIL bp_busy(c=%0d): got %b want %b", c, busy, m_busy()); end
        end
        n_vec++; if (we_seen != 0) begin n_err++; $display("FAIL bp_no_write: got %0d writes want 0", we_seen); end
        n_vec++; if (!saw_busy || idx != DEPTH - 1) begin n_err++; $display("FAIL bp_held: got busy_seen=%0d accepted=%0d want 1/%0d", saw_busy, idx, DEPTH - 1); end
        mem_ready = 1;
        for (int c = 0; c < 30; c++) begin
            plot = (idx < 6) && !busy;
            if (plot) begin x = px[idx]; y = py[idx]; color = pc[idx]; idx++; end
            tick();
            if (mem_we) begin
                if (nwr < 6) begin got[nwr] = {mem_addr, mem_data}; wr_cyc[nwr] = c; end
                nwr++;
            end
        end
        plot = 0;
        n_vec++; if (nwr != 6) begin n_err++; $display("FAIL bp_count: got %0d writes want 6", nwr); end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (got[k] !== {15'(int'(py[k]) * H_RES + int'(px[k])), pc[k]}) begin
                n_err++; $display("FAIL bp_order[%0d]: got %0h want %0h", k, got[k], {15'(int'(py[k]) * H_RES + int'(px[k])), pc[k]});
            end
        end
        n_vec++; if (wr_cyc[1] != wr_cyc[0] + 1 || wr_cyc[2] != wr_cyc[1] + 1) begin
            n_err++; $display("FAIL bp_consecutive: got cycles %0d,%0d,%0d want consecutive", wr_cyc[0], wr_cyc[1], wr_cyc[2]);
        end
        n_vec++; if (ovf_count !== 8'd0) begin n_err++; $display("FAIL bp_ovf: got %0d want 0", ovf_count); end
    endtask

    task automatic test_overflow();
        logic [7:0]  px[10];
        logic [6:0]  py[10];
        logic [2:0]  pc[10];
        logic [17:0] got[$];
        do_reset();
        mem_ready = 0;
        for (int i = 0; i < 10; i++) begin
            px[i] = 8'($urandom_range(0, H_RES - 1));
            py[i] = 7'($urandom_range(0, V_RES - 1));
            pc[i] = 3'($urandom);
            plot = 1; x = px[i]; y = py[i]; color = pc[i];
            tick();
        end
        plot = 0;
        n_vec++; if (ovf_count !== 8'(10 - (DEPTH - 1))) begin n_err++; $display("FAIL ovf_count: got %0d want %0d", ovf_count, 10 - (DEPTH - 1)); end
        mem_ready = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_we) got.push_back({mem_addr, mem_data});
        end
        n_vec++; if (got.size() != DEPTH - 1) begin n_err++; $display("FAIL ovf_writes: got %0d want %0d", got.size(), DEPTH - 1); end
        while (got.size() < 3) got.push_back('x);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (got[k] !== {15'(int'(py[k]) * H_RES + int'(px[k])), pc[k]}) begin
                n_err++; $display("FAIL ovf_pixel[%0d]: got %0h want %0h", k, got[k], {15'(int'(py[k]) * H_RES + int'(px[k])), pc[k]});
            end
        end
    endtask

    task automatic test_flush();
        int nacc = 0;
        int nwr = 0;
        int done_hi = 0;
        bit done_seen = 0;
        do_reset();
        for (int c = 0; c < 40 && nacc < 3; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            plot = !busy;
            if (plot) begin
                x = 8'($urandom_range(0, H_RES - 1)); y = 7'($urandom_range(0, V_RES - 1));
                color = 3'($urandom); nacc++;
            end
            tick();
            if (mem_we) nwr++;
        end
        plot = 0;
        flush_req = 1;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            tick();
            if (mem_we) nwr++;
            n_vec++; if (flush_done !== m_fd) begin n_err++; $display("FAIL flush_track(c=%0d): got %b want %b", c, flush_done, m_fd); end
            if (flush_done === 1'b1) begin
                done_seen = 1;
                n_vec++; if (nwr != 3) begin n_err++; $display("FAIL flush_after_writes: got %0d writes at done want 3", nwr); end
            end
        end
        if (!done_seen) begin n_vec++; n_err++; $display("FAIL flush_timeout: got no flush_done want 1 within 40 cycles"); end
        flush_req = 0;
        tick();
        n_vec++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL flush_release: got %b want 0", flush_done); end
        // Aborted flush: request withdrawn while pixels are still pending
        mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            plot = 1; x = 8'(10 + i); y = 7'd3; color = 3'd2;
            tick();
        end
        plot = 0;
        flush_req = 1;
        for (int i = 0; i < 3; i++) begin tick(); if (flush_done) done_hi++; end
        flush_req = 0;
        mem_ready = 1;
        for (int i = 0; i < 8; i++) begin tick(); if (flush_done) done_hi++; end
        n_vec++; if (done_hi != 0) begin n_err++; $display("FAIL flush_abort: got %0d done cycles want 0", done_hi); end
    endtask

    task automatic test_reset_mid_drain();
        int nwe = 0;
        do_reset();
        mem_ready = 0;
        plot = 1; x = 8'd200; y = 7'd1; color = 3'd1;
        tick();
        for (int i = 0; i < 5; i++) begin
            x = 8'(20 + i); y = 7'd4; color = 3'd4;
            tick();
        end
        plot = 0;
        n_vec++; if (oob_count !== 8'd1 || ovf_count !== 8'd2) begin n_err++; $display("FAIL mid_pre_counts: got %0d/%0d want 1/2", oob_count, ovf_count); end
        reset = 1;
        tick();
        reset = 0;
        mem_ready = 1;
        for (int i = 0; i < 10; i++) begin tick(); if (mem_we !== 1'b0) nwe++; end
        n_vec++; if (nwe != 0) begin n_err++; $display("FAIL mid_no_write: got %0d writes want 0", nwe); end
        n_vec++; if (oob_count !== 8'd0 || ovf_count !== 8'd0) begin n_err++; $display("FAIL mid_counters: got %0d/%0d want 0/0", oob_count, ovf_count); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_ready = 1;
        plot = 1; x = 8'd200; y = 7'd0; color = 3'd0;
        for (int i = 0; i < 260; i++) tick();
        plot = 0;
        n_vec++; if (oob_count !== 8'd255) begin n_err++; $display("FAIL sat_oob: got %0d want 255", oob_count); end
        mem_ready = 0;
        plot = 1; x = 8'd10; y = 7'd10;
        for (int i = 0; i < 270; i++) tick();
        plot = 0;
        n_vec++; if (ovf_count !== 8'd255 || oob_count !== 8'd255) begin n_err++; $display("FAIL sat_ovf: got ovf=%0d oob=%0d want 255/255", ovf_count, oob_count); end
    endtask

    task automatic test_random();
        logic [36:0] act;
        logic [36:0] exp;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            plot      = ($urandom_range(0, 3) != 0) && (!busy || $urandom_range(0, 3) == 0);
            x         = 8'($urandom_range(0, 175));
            y         = 7'($urandom_range(0, 127));
            color     = 3'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) flush_req = ~flush_req;
            tick();
            exp = {m_we, m_addr, m_data, m_busy(), m_fd, 8'(m_oob), 8'(m_ovf)};
            act = {mem_we, mem_addr, mem_data, busy, flush_done, oob_count, ovf_count};
            n_vec++;
            if (act !== exp) begin
                n_err++; $display("FAIL random(c=%0d): got we/addr/data/busy/done/oob/ovf=%h want %h", c, act, exp);
            end
        end
        plot = 0;
        flush_req = 0;
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_corners();
        test_backpressure();
        test_overflow();
        test_flush();
        test_reset_mid_drain();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
